// File: rtl/rf_wr_arbiter.sv
// Register file write-port arbiter: round-robin over ALU, load and MDU
// writebacks, plus a dedicated link port that owns register 31.
module rf_wr_arbiter #(
  parameter int DW       = 32,
  parameter int LINK_REG = 31
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          AluVld,
  input  logic [4:0]    AluRw,
  input  logic [DW-1:0] AluData,
  output logic          AluRdy,
  input  logic          LdVld,
  input  logic [4:0]    LdRw,
  input  logic [DW-1:0] LdData,
  output logic          LdRdy,
  input  logic          MduVld,
  input  logic [4:0]    MduRw,
  input  logic [DW-1:0] MduData,
  output logic          MduRdy,
  input  logic          LinkReq,
  input  logic [29:0]   LinkPC,
  output logic          WrEn,
  output logic [4:0]    Rw,
  output logic [DW-1:0] busW,
  output logic          R31Wr,
  output logic [29:0]   R31,
  output logic [31:0]   Pend
);

  localparam logic [4:0] LINK = LINK_REG[4:0];

  typedef enum logic [1:0] {
    P_ALU = 2'd0,
    P_LD  = 2'd1,
    P_MDU = 2'd2
  } ptr_t;

  ptr_t          ptr_q;
  ptr_t          ptr_d;
  logic [2:0]    elig;
  logic [2:0]    gnt;
  logic [4:0]    sel_rw;
  logic [DW-1:0] sel_data;

  // Eligibility: link write always wins register 31
  always_comb begin
    elig    = '0;
    elig[0] = AluVld && !(LinkReq && AluRw == LINK);
    elig[1] = LdVld  && !(LinkReq && LdRw  == LINK);
    elig[2] = MduVld && !(LinkReq && MduRw == LINK);
  end

  // Round-robin search starting at the pointer
  always_comb begin
    gnt = '0;
    unique case (ptr_q)
      P_ALU: begin
        if      (elig[0]) gnt = 3'b001;
        else if (elig[1]) gnt = 3'b010;
        else if (elig[2]) gnt = 3'b100;
      end
      P_LD: begin
        if      (elig[1]) gnt = 3'b010;
        else if (elig[2]) gnt = 3'b100;
        else if (elig[0]) gnt = 3'b001;
      end
      P_MDU: begin
        if      (elig[2]) gnt = 3'b100;
        else if (elig[0]) gnt = 3'b001;
        else if (elig[1]) gnt = 3'b010;
      end
      default: gnt = '0;
    endcase
  end

  // Next pointer and selected request
  always_comb begin
    ptr_d    = ptr_q;
    sel_rw   = '0;
    sel_data = '0;
    unique case (1'b1)
      gnt[0]: begin
        ptr_d    = P_LD;
        sel_rw   = AluRw;
        sel_data = AluData;
      end
      gnt[1]: begin
        ptr_d    = P_MDU;
        sel_rw   = LdRw;
        sel_data = LdData;
      end
      gnt[2]: begin
        ptr_d    = P_ALU;
        sel_rw   = MduRw;
        sel_data = MduData;
      end
      default: ptr_d = ptr_q;
    endcase
  end

  assign AluRdy = gnt[0];
  assign LdRdy  = gnt[1];
  assign MduRdy = gnt[2];

  // Output stage; writes to r0 are consumed but never enabled
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      ptr_q <= P_ALU;
      WrEn  <= 1'b0;
      Rw    <= '0;
      busW  <= '0;
      R31Wr <= 1'b0;
      R31   <= '0;
    end else begin
      ptr_q <= ptr_d;
      WrEn  <= |gnt && sel_rw != 5'd0;
      if (|gnt) begin
        Rw   <= sel_rw;
        busW <= sel_data;
      end
      R31Wr <= LinkReq;
      if (LinkReq) R31 <= LinkPC;
    end
  end

  // Pending-write map from the output registers
  always_comb begin
    Pend = '0;
    if (WrEn)  Pend[Rw]   = 1'b1;
    if (R31Wr) Pend[LINK] = 1'b1;
    Pend[0] = 1'b0;
  end

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Directed bench for rf_wr_arbiter: arbitration order, link collisions,
// zero target, fairness and mid-operation reset.
module tb_rf_wr_arbiter;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        AluVld, LdVld, MduVld, LinkReq;
  logic [4:0]  AluRw, LdRw, MduRw;
  logic [31:0] AluData, LdData, MduData;
  logic [29:0] LinkPC;
  logic        AluRdy, LdRdy, MduRdy;
  logic        WrEn, R31Wr;
  logic [4:0]  Rw;
  logic [31:0] busW, Pend;
  logic [29:0] R31;

  int total = 0;
  int bad   = 0;

  rf_wr_arbiter #(.DW(32), .LINK_REG(31)) dut (
    .Clk(Clk), .Reset(Reset),
    .AluVld(AluVld), .AluRw(AluRw), .AluData(AluData), .AluRdy(AluRdy),
    .LdVld(LdVld), .LdRw(LdRw), .LdData(LdData), .LdRdy(LdRdy),
    .MduVld(MduVld), .MduRw(MduRw), .MduData(MduData), .MduRdy(MduRdy),
    .LinkReq(LinkReq), .LinkPC(LinkPC),
    .WrEn(WrEn), .Rw(Rw), .busW(busW),
    .R31Wr(R31Wr), .R31(R31), .Pend(Pend)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rdy(input string tag, input logic [2:0] exp);
    chk(tag, {29'd0, MduRdy, LdRdy, AluRdy}, {29'd0, exp});
  endtask

  task automatic outs(input string tag, input logic en, input logic [4:0] rw,
                      input logic [31:0] d, input logic [31:0] pend);
    chk({tag, ".wren"}, {31'd0, WrEn}, {31'd0, en});
    chk({tag, ".rw"}, {27'd0, Rw}, {27'd0, rw});
    chk({tag, ".busw"}, busW, d);
    chk({tag, ".pend"}, Pend, pend);
    chk({tag, ".nocoll"}, {31'd0, WrEn && Rw == 5'd31 && R31Wr}, 32'd0);
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    Reset = 1'b1;
    AluVld = 0; LdVld = 0; MduVld = 0; LinkReq = 0;
    AluRw = 0; LdRw = 0; MduRw = 0;
    AluData = 0; LdData = 0; MduData = 0; LinkPC = 0;
    tick();
    outs("rst", 1'b0, 5'd0, 32'd0, 32'd0);
    chk("rst.r31wr", {31'd0, R31Wr}, 32'd0);
    chk("rst.r31", {2'd0, R31}, 32'd0);
    Reset = 1'b0;

    // All three request at once: ALU, Ld, Mdu in order
    AluVld = 1; AluRw = 5'd1; AluData = 32'h11;
    LdVld  = 1; LdRw  = 5'd2; LdData  = 32'h22;
    MduVld = 1; MduRw = 5'd3; MduData = 32'h33;
    #1; rdy("rr.c1", 3'b001);
    tick(); AluVld = 0; #1;
    outs("rr.o1", 1'b1, 5'd1, 32'h11, 32'h2);
    rdy("rr.c2", 3'b010);
    tick(); LdVld = 0; #1;
    outs("rr.o2", 1'b1, 5'd2, 32'h22, 32'h4);
    rdy("rr.c3", 3'b100);
    tick(); MduVld = 0; #1;
    outs("rr.o3", 1'b1, 5'd3, 32'h33, 32'h8);
    tick();
    outs("idle", 1'b0, 5'd3, 32'h33, 32'h0);

    // Load to r31 collides with link write
    LdVld = 1; LdRw = 5'd31; LdData = 32'hAAAA_0000;
    LinkReq = 1; LinkPC = 30'h0000_1001;
    #1; rdy("lnk.c1", 3'b000);
    tick(); LinkReq = 0; #1;
    chk("lnk.r31wr", {31'd0, R31Wr}, 32'd1);
    chk("lnk.r31", {2'd0, R31}, 32'h1001);
    outs("lnk.o1", 1'b0, 5'd3, 32'h33, 32'h8000_0000);
    rdy("lnk.c2", 3'b010);
    tick(); LdVld = 0; #1;
    outs("lnk.o2", 1'b1, 5'd31, 32'hAAAA_0000, 32'h8000_0000);
    chk("lnk.r31wr0", {31'd0, R31Wr}, 32'd0);
    chk("lnk.r31hold", {2'd0, R31}, 32'h1001);

    // Zero target consumed without a write; pointer moves past ALU
    AluVld = 1; AluRw = 5'd0; AluData = 32'h1234;
    #1; rdy("zero.c", 3'b001);
    tick(); AluVld = 0; #1;
    chk("zero.wren", {31'd0, WrEn}, 32'd0);
    chk("zero.pend", Pend, 32'd0);
    LdVld = 1; LdRw = 5'd4; LdData = 32'h44;
    AluVld = 1; AluRw = 5'd6; AluData = 32'h66;
    #1; rdy("zero.ldfirst", 3'b010);
    tick(); LdVld = 0; #1;
    outs("zero.o1", 1'b1, 5'd4, 32'h44, 32'h10);
    rdy("zero.alu", 3'b001);
    tick(); AluVld = 0; #1;
    outs("zero.o2", 1'b1, 5'd6, 32'h66, 32'h40);

    // Mdu and ALU both streaming: grants alternate
    MduVld = 1; MduRw = 5'd9;  MduData = 32'h99;
    AluVld = 1; AluRw = 5'd10; AluData = 32'hA0;
    #1; rdy("alt.c1", 3'b100);
    tick();
    outs("alt.o1", 1'b1, 5'd9, 32'h99, 32'h200);
    rdy("alt.c2", 3'b001);
    tick();
    outs("alt.o2", 1'b1, 5'd10, 32'hA0, 32'h400);
    rdy("alt.c3", 3'b100);
    tick(); MduVld = 0; AluVld = 0; #1;
    outs("alt.o3", 1'b1, 5'd9, 32'h99, 32'h200);

    // Reset drops a registered write; held request re-granted after
    AluVld = 1; AluRw = 5'd5; AluData = 32'h55;
    #1; rdy("rst2.c", 3'b001);
    tick();
    outs("rst2.o", 1'b1, 5'd5, 32'h55, 32'h20);
    #2 Reset = 1'b1;
    #1;
    outs("rst2.drop", 1'b0, 5'd0, 32'h0, 32'h0);
    tick();
    Reset = 1'b0;
    #1; rdy("rst2.regrant", 3'b001);
    tick(); AluVld = 0; #1;
    outs("rst2.o2", 1'b1, 5'd5, 32'h55, 32'h20);

    // Link and ALU write in the same cycle
    LinkReq = 1; LinkPC = 30'h0000_2222;
    AluVld = 1; AluRw = 5'd7; AluData = 32'h77;
    #1; rdy("both.c", 3'b001);
    tick(); LinkReq = 0; AluVld = 0; #1;
    outs("both.o", 1'b1, 5'd7, 32'h77, 32'h8000_0080);
    chk("both.r31wr", {31'd0, R31Wr}, 32'd1);
    chk("both.r31", {2'd0, R31}, 32'h2222);
    tick();
    outs("both.idle", 1'b0, 5'd7, 32'h77, 32'h0);
    chk("both.r31wr0", {31'd0, R31Wr}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
